// File: rtl/chacha_block_if.sv
// Handshake and job bundle between a keystream consumer and chacha_block_engine.
// The consumer drives the job inputs and block_ready; the engine drives everything else.
interface chacha_block_if;
    logic         start;
    logic [255:0] key;
    logic [95:0]  nonce;
    logic [31:0]  counter_in;
    logic [3:0]   num_blocks;
    logic [511:0] block_out;
    logic         block_valid;
    logic         block_ready;
    logic         busy;
    logic [3:0]   blocks_produced;
    logic         done;

    modport master (
        output start, key, nonce, counter_in, num_blocks, block_ready,
        input  block_out, block_valid, busy, blocks_produced, done
    );

    modport slave (
        input  start, key, nonce, counter_in, num_blocks, block_ready,
        output block_out, block_valid, busy, blocks_produced, done
    );
endinterface

// File: rtl/chacha_block_engine.sv
// ChaCha block function: LANES quarter-rounds per cycle for ROUNDS rounds, then feed-forward,
// streaming num_blocks consecutive 512-bit keystream blocks over valid/ready.
//
// state  | meaning
// IDLE   | waiting for start; job inputs latched on start
// LOAD   | initial state written to working and saved matrices
// ROUND  | 4*ROUNDS/LANES quarter-round cycles, round counter counts down
// FINAL  | feed-forward add into block_out, raise block_valid
// OUTPUT | hold block until accepted
// NEXT   | advance block counter for the next block of the job
module chacha_block_engine #(
    parameter int ROUNDS = 20,
    parameter int LANES  = 1
) (
    input  logic          clk,
    input  logic          rst,
    chacha_block_if.slave bus
);
    localparam int NCYC = 4 * ROUNDS / LANES;
    localparam int GCYC = 4 / LANES;
    localparam int RCW  = $clog2(NCYC);
    localparam logic [31:0] SIGMA [4] = '{32'h61707865, 32'h3320646e, 32'h79622d32, 32'h6b206574};

    typedef enum logic [2:0] {IDLE, LOAD, ROUND, FINAL, OUTPUT, NEXT} state_t;

    state_t         state;
    logic [255:0]   key_q;
    logic [95:0]    nonce_q;
    logic [31:0]    ctr_q;
    logic [3:0]     nblk_q;
    logic [RCW-1:0] rnd_cnt;
    logic [31:0]    work    [16];
    logic [31:0]    saved   [16];
    logic [31:0]    work_nx [16];
    logic [31:0]    init_st [16];

    function automatic logic [31:0] rotl(input logic [31:0] x, input int n);
        return (x << n) | (x >> (32 - n));
    endfunction

    function automatic logic [127:0] quarter(input logic [31:0] a_i, input logic [31:0] b_i,
                                             input logic [31:0] c_i, input logic [31:0] d_i);
        logic [31:0] a, b, c, d;
        a = a_i; b = b_i; c = c_i; d = d_i;
        a = a + b; d = rotl(d ^ a, 16);
        c = c + d; b = rotl(b ^ c, 12);
        a = a + b; d = rotl(d ^ a, 8);
        c = c + d; b = rotl(b ^ c, 7);
        return {d, c, b, a};
    endfunction

    always_comb begin
        for (int i = 0; i < 4; i++) init_st[i] = SIGMA[i];
        for (int i = 0; i < 8; i++) init_st[4+i] = key_q[32*i +: 32];
        init_st[12] = ctr_q;
        for (int i = 0; i < 3; i++) init_st[13+i] = nonce_q[32*i +: 32];
    end

    // rnd_cnt counts down, so the step within a double round is recovered from its distance to NCYC-1
    always_comb begin
        int           step, pos, grp_j, q;
        logic         diag;
        logic [3:0]   ia, ib, ic, id;
        logic [127:0] r;
        work_nx = work;
        step  = NCYC - 1 - int'(rnd_cnt);
        pos   = step % (2 * GCYC);
        diag  = (pos >= GCYC);
        grp_j = pos % GCYC;
        q  = 0;
        ia = '0; ib = '0; ic = '0; id = '0;
        r  = '0;
        for (int k = 0; k < LANES; k++) begin
            q  = grp_j * LANES + k;
            ia = 4'(q);
            ib = 4'(4  + (diag ? (q + 1) % 4 : q));
            ic = 4'(8  + (diag ? (q + 2) % 4 : q));
            id = 4'(12 + (diag ? (q + 3) % 4 : q));
            r  = quarter(work[ia], work[ib], work[ic], work[id]);
            work_nx[ia] = r[31:0];
            work_nx[ib] = r[63:32];
            work_nx[ic] = r[95:64];
            work_nx[id] = r[127:96];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state               <= IDLE;
            key_q               <= '0;
            nonce_q             <= '0;
            ctr_q               <= '0;
            nblk_q              <= '0;
            rnd_cnt             <= '0;
            for (int i = 0; i < 16; i++) begin
                work[i]  <= '0;
                saved[i] <= '0;
            end
            bus.block_out       <= '0;
            bus.block_valid     <= 1'b0;
            bus.busy            <= 1'b0;
            bus.blocks_produced <= '0;
            bus.done            <= 1'b0;
        end else begin
            bus.done <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        key_q               <= bus.key;
                        nonce_q             <= bus.nonce;
                        ctr_q               <= bus.counter_in;
                        nblk_q              <= (bus.num_blocks == 4'd0) ? 4'd1 : bus.num_blocks;
                        bus.blocks_produced <= '0;
                        bus.busy            <= 1'b1;
                        state               <= LOAD;
                    end
                end
                LOAD: begin
                    for (int i = 0; i < 16; i++) begin
                        work[i]  <= init_st[i];
                        saved[i] <= init_st[i];
                    end
                    rnd_cnt <= RCW'(NCYC - 1);
                    state   <= ROUND;
                end
                ROUND: begin
                    for (int i = 0; i < 16; i++) work[i] <= work_nx[i];
                    if (rnd_cnt == '0) state <= FINAL;
                    else               rnd_cnt <= rnd_cnt - 1'b1;
                end
                FINAL: begin
                    for (int i = 0; i < 16; i++) bus.block_out[32*i +: 32] <= work[i] + saved[i];
                    bus.block_valid <= 1'b1;
                    state           <= OUTPUT;
                end
                OUTPUT: begin
                    if (bus.block_ready) begin
                        bus.block_valid     <= 1'b0;
                        bus.blocks_produced <= bus.blocks_produced + 4'd1;
                        if (bus.blocks_produced + 4'd1 == nblk_q) begin
                            bus.done <= 1'b1;
                            bus.busy <= 1'b0;
                            state    <= IDLE;
                        end else begin
                            state <= NEXT;
                        end
                    end
                end
                NEXT: begin
                    ctr_q <= ctr_q + 32'd1;
                    state <= LOAD;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_chacha_block_engine.sv
// Bench for chacha_block_engine: a whole-block reference model checked every cycle on the
// 20-round single-lane instance, plus RFC 8439 literal checks on other lane/round settings.
module tb_chacha_block_engine;
    localparam int NCYC_P = 80;
    localparam logic [255:0] RFC_KEY = {32'h1f1e1d1c, 32'h1b1a1918, 32'h17161514, 32'h13121110,
                                        32'h0f0e0d0c, 32'h0b0a0908, 32'h07060504, 32'h03020100};
    localparam logic [95:0]  RFC_NONCE = {32'h00000000, 32'h4a000000, 32'h09000000};
    localparam logic [511:0] RFC_BLK = {
        32'h4e3c50a2, 32'he883d0cb, 32'hb94e16de, 32'hd19c12b5,
        32'ha2028bd9, 32'h05d7c214, 32'h09aa9f07, 32'h466482d2,
        32'h4e6cd4c3, 32'h9aaa2204, 32'h0368c033, 32'hc7f4d1c7,
        32'hc47120a3, 32'h1fdd0f50, 32'h15593bd1, 32'he4e7f110};

    logic clk = 1'b0;
    logic rst;
    logic start2;
    int   cyc = 0;
    int   tests = 0;
    int   fails = 0;
    int   e0 = 0;
    int   done_cnt = 0;

    chacha_block_if bus();
    chacha_block_if if2();
    chacha_block_if if4();
    chacha_block_if if8();

    chacha_block_engine #(.ROUNDS(20), .LANES(1)) u_dut (.clk(clk), .rst(rst), .bus(bus));
    chacha_block_engine #(.ROUNDS(20), .LANES(2)) u_l2  (.clk(clk), .rst(rst), .bus(if2));
    chacha_block_engine #(.ROUNDS(20), .LANES(4)) u_l4  (.clk(clk), .rst(rst), .bus(if4));
    chacha_block_engine #(.ROUNDS(8),  .LANES(2)) u_r8  (.clk(clk), .rst(rst), .bus(if8));

    assign if2.start = start2;      assign if4.start = start2;      assign if8.start = start2;
    assign if2.key = bus.key;       assign if4.key = bus.key;       assign if8.key = bus.key;
    assign if2.nonce = bus.nonce;   assign if4.nonce = bus.nonce;   assign if8.nonce = bus.nonce;
    assign if2.counter_in = bus.counter_in;
    assign if4.counter_in = bus.counter_in;
    assign if8.counter_in = bus.counter_in;
    assign if2.num_blocks = bus.num_blocks;
    assign if4.num_blocks = bus.num_blocks;
    assign if8.num_blocks = bus.num_blocks;
    assign if2.block_ready = 1'b1;  assign if4.block_ready = 1'b1;  assign if8.block_ready = 1'b1;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] rl(input logic [31:0] x, input int n);
        return (x << n) | (x >> (32 - n));
    endfunction

    function automatic logic [127:0] qr_ref(input logic [31:0] a0, input logic [31:0] b0,
                                            input logic [31:0] c0, input logic [31:0] d0);
        logic [31:0] a, b, c, d;
        a = a0; b = b0; c = c0; d = d0;
        a += b; d ^= a; d = rl(d, 16);
        c += d; b ^= c; b = rl(b, 12);
        a += b; d ^= a; d = rl(d, 8);
        c += d; b ^= c; b = rl(b, 7);
        return {d, c, b, a};
    endfunction

    function automatic logic [511:0] chacha_ref(input logic [255:0] k, input logic [95:0] n,
                                                input logic [31:0] c, input int rounds);
        logic [31:0]  s [16];
        logic [31:0]  x [16];
        logic [127:0] r;
        logic [511:0] o;
        int sched [8][4] = '{'{0,4,8,12}, '{1,5,9,13}, '{2,6,10,14}, '{3,7,11,15},
                             '{0,5,10,15}, '{1,6,11,12}, '{2,7,8,13}, '{3,4,9,14}};
        s[0] = 32'h61707865; s[1] = 32'h3320646e; s[2] = 32'h79622d32; s[3] = 32'h6b206574;
        for (int i = 0; i < 8; i++) s[4+i] = k[32*i +: 32];
        s[12] = c;
        for (int i = 0; i < 3; i++) s[13+i] = n[32*i +: 32];
        x = s;
        for (int dr = 0; dr < rounds / 2; dr++) begin
            for (int g = 0; g < 8; g++) begin
                r = qr_ref(x[sched[g][0]], x[sched[g][1]], x[sched[g][2]], x[sched[g][3]]);
                x[sched[g][0]] = r[31:0];
                x[sched[g][1]] = r[63:32];
                x[sched[g][2]] = r[95:64];
                x[sched[g][3]] = r[127:96];
            end
        end
        for (int i = 0; i < 16; i++) o[32*i +: 32] = x[i] + s[i];
        return o;
    endfunction

    task automatic chk(input string nm, input logic [511:0] act, input logic [511:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic chk_int(input string nm, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    // Inputs as seen by the DUT at each rising edge
    logic         s_seen = 1'b0, s_rst, s_start, s_ready;
    logic [255:0] s_key;
    logic [95:0]  s_nonce;
    logic [31:0]  s_ctr;
    logic [3:0]   s_nb;
    always @(posedge clk) begin
        s_seen  <= 1'b1;
        s_rst   <= rst;
        s_start <= bus.start;
        s_ready <= bus.block_ready;
        s_key   <= bus.key;
        s_nonce <= bus.nonce;
        s_ctr   <= bus.counter_in;
        s_nb    <= bus.num_blocks;
    end

    int           m_active = 0, m_valid = 0, m_wait = 0, m_produced = 0, m_total = 0;
    int           m_done = 0, chk_zero = 0;
    logic [255:0] m_key;
    logic [95:0]  m_nonce;
    logic [31:0]  m_ctr;
    logic [511:0] m_blk;

    always @(negedge clk) begin
        if (s_seen) begin
            m_done = 0;
            chk_zero = 0;
            if (s_rst) begin
                m_active = 0; m_valid = 0; m_produced = 0; chk_zero = 1;
            end else if (m_active != 0) begin
                if (m_valid != 0) begin
                    if (s_ready) begin
                        m_valid = 0;
                        m_produced++;
                        if (m_produced == m_total) begin
                            m_active = 0;
                            m_done = 1;
                        end else begin
                            m_ctr  = m_ctr + 32'd1;
                            m_wait = 3 + NCYC_P;
                        end
                    end
                end else begin
                    m_wait--;
                    if (m_wait == 0) begin
                        m_valid = 1;
                        m_blk = chacha_ref(m_key, m_nonce, m_ctr, 20);
                    end
                end
            end else if (s_start) begin
                m_key = s_key; m_nonce = s_nonce; m_ctr = s_ctr;
                m_total = (s_nb == 4'd0) ? 1 : int'(s_nb);
                m_produced = 0;
                m_active = 1;
                m_wait = 2 + NCYC_P;
            end
            if (bus.done) done_cnt++;
            chk_int("valid", int'(bus.block_valid), m_valid);
            chk_int("busy", int'(bus.busy), m_active);
            chk_int("blocks_produced", int'(bus.blocks_produced), m_produced);
            chk_int("done", int'(bus.done), m_done);
            if (m_valid != 0) chk("block_out", bus.block_out, m_blk);
            if (chk_zero != 0) chk("reset_block_out", bus.block_out, '0);
        end
    end

    int           v_cyc [3] = '{-1, -1, -1};
    logic [511:0] v_blk [3];
    always @(negedge clk) begin
        if (if2.block_valid && v_cyc[0] < 0) begin v_cyc[0] = cyc; v_blk[0] = if2.block_out; end
        if (if4.block_valid && v_cyc[1] < 0) begin v_cyc[1] = cyc; v_blk[1] = if4.block_out; end
        if (if8.block_valid && v_cyc[2] < 0) begin v_cyc[2] = cyc; v_blk[2] = if8.block_out; end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_job(input logic [255:0] k, input logic [95:0] n,
                             input logic [31:0] c, input logic [3:0] nb);
        bus.key = k; bus.nonce = n; bus.counter_in = c; bus.num_blocks = nb;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        e0 = cyc;
    endtask

    task automatic wait_valid(output int lat);
        int n = 0;
        while (!bus.block_valid && n < 400) begin tick(); n++; end
        if (!bus.block_valid) begin
            tests++; fails++;
            $display("FAIL wait_valid: no block_valid within %0d cycles", n);
        end
        lat = cyc - e0;
    endtask

    task automatic wait_done();
        int n = 0;
        while (!bus.done && n < 1000) begin tick(); n++; end
        if (!bus.done) begin
            tests++; fails++;
            $display("FAIL wait_done: no done within %0d cycles", n);
        end
    endtask

    task automatic rfc_run(input string tag);
        int lat;
        start_job(RFC_KEY, RFC_NONCE, 32'd1, 4'd1);
        wait_valid(lat);
        chk_int({tag, "_valid_edge"}, lat, 82);
        chk({tag, "_block"}, bus.block_out, RFC_BLK);
        wait_done();
        chk_int({tag, "_done_edge"}, cyc - e0, 83);
    endtask

    initial begin
        int lat, d0;
        rst = 1'b1; start2 = 1'b0;
        bus.start = 1'b0; bus.block_ready = 1'b1;
        bus.key = '0; bus.nonce = '0; bus.counter_in = '0; bus.num_blocks = '0;

        chk("model_qr_rfc", {96'h0, qr_ref(32'h11111111, 32'h01020304, 32'h9b8d6f43, 32'h01234567)},
            {96'h0, 32'h5881c4bb, 32'h4581472e, 32'hcb1cf8ce, 32'hea2a92f4});
        chk("model_block_rfc", chacha_ref(RFC_KEY, RFC_NONCE, 32'd1, 20), RFC_BLK);

        repeat (3) tick();
        rst = 1'b0;
        tick();
        chk_int("reset_busy", int'(bus.busy), 0);
        chk_int("reset_valid", int'(bus.block_valid), 0);
        chk_int("reset_produced", int'(bus.blocks_produced), 0);

        // RFC vector on every instance at once
        start2 = 1'b1;
        rfc_run("rfc_l1");
        start2 = 1'b0;
        chk_int("rfc_l2_valid_edge", v_cyc[0] - e0, 42);
        chk("rfc_l2_block", v_blk[0], RFC_BLK);
        chk_int("rfc_l4_valid_edge", v_cyc[1] - e0, 22);
        chk("rfc_l4_block", v_blk[1], RFC_BLK);
        chk_int("r8_l2_valid_edge", v_cyc[2] - e0, 18);
        chk("r8_l2_block", v_blk[2], chacha_ref(RFC_KEY, RFC_NONCE, 32'd1, 8));

        // backpressure
        tick();
        bus.block_ready = 1'b0;
        start_job(RFC_KEY, RFC_NONCE, 32'd1, 4'd1);
        wait_valid(lat);
        chk_int("bp_valid_edge", lat, 82);
        for (int i = 0; i < 10; i++) begin
            tick();
            chk_int("bp_valid_held", int'(bus.block_valid), 1);
            chk("bp_block_held", bus.block_out, RFC_BLK);
        end
        bus.block_ready = 1'b1;
        tick();
        chk_int("bp_done_after_ready", int'(bus.done), 1);

        // counter wrap across a three-block job
        tick();
        d0 = done_cnt;
        start_job(~RFC_KEY, {32'hcafef00d, 32'h01234567, 32'h89abcdef}, 32'hffffffff, 4'd3);
        wait_done();
        chk_int("wrap_produced", int'(bus.blocks_produced), 3);
        repeat (3) tick();
        chk_int("wrap_done_pulses", done_cnt - d0, 1);

        // reset during ROUND cycle 40
        start_job(RFC_KEY, RFC_NONCE, 32'd1, 4'd1);
        repeat (41) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk_int("midrst_busy", int'(bus.busy), 0);
        chk_int("midrst_valid", int'(bus.block_valid), 0);
        chk_int("midrst_produced", int'(bus.blocks_produced), 0);
        chk_int("midrst_done", int'(bus.done), 0);
        chk("midrst_block", bus.block_out, '0);
        d0 = done_cnt;
        repeat (100) tick();
        chk_int("midrst_no_done", done_cnt - d0, 0);
        rfc_run("post_rst");

        // num_blocks=0 with a start pulse and input changes mid-job
        tick();
        d0 = done_cnt;
        start_job(RFC_KEY ^ 256'h5a5a, RFC_NONCE, 32'h12345678, 4'd0);
        repeat (20) tick();
        bus.start = 1'b1; bus.num_blocks = 4'd5; bus.counter_in = '0; bus.key = '1;
        tick();
        bus.start = 1'b0;
        wait_done();
        chk_int("nb0_produced", int'(bus.blocks_produced), 1);
        repeat (90) tick();
        chk_int("nb0_idle_after", int'(bus.busy), 0);
        chk_int("nb0_done_pulses", done_cnt - d0, 1);

        // back-to-back: start on the done cycle
        start_job(RFC_KEY, RFC_NONCE, 32'd5, 4'd2);
        wait_done();
        bus.start = 1'b1; bus.counter_in = 32'd1; bus.num_blocks = 4'd1;
        tick();
        bus.start = 1'b0;
        e0 = cyc;
        wait_valid(lat);
        chk_int("b2b_valid_edge", lat, 82);
        chk("b2b_block", bus.block_out, RFC_BLK);
        wait_done();
        repeat (3) tick();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule
